// File: rtl/flash_reader.sv
// flash_reader: SPI mode-0 master that streams a block of bytes out of a
// serial flash using the single-byte READ command, presenting each received
// byte with a one-cycle valid strobe.
module flash_reader #(
  parameter int unsigned StartupWaitCycles = 0,
  parameter int unsigned ByteCountBitWidth = 16,
  parameter logic [7:0]  ReadCommand       = 8'h03
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [23:0]                  address,
  input  logic [ByteCountBitWidth-1:0] byte_count,
  output logic                         busy,
  output logic [7:0]                   data_out,
  output logic                         data_out_valid,
  output logic                         done,
  output logic                         flash_clk,
  output logic                         flash_mosi,
  input  logic                         flash_miso,
  output logic                         flash_cs_n
);

  typedef enum logic [1:0] {
    StStartup,
    StIdle,
    StShift,
    StRead
  } state_t;

  localparam state_t ResetState = (StartupWaitCycles != 0) ? StStartup : StIdle;
  localparam logic [ByteCountBitWidth-1:0] OneByte = ByteCountBitWidth'(1);

  state_t                         state;
  state_t                         state_next;
  logic [31:0]                    startup_cnt;
  logic                           phase;        // 0 = L half (flash_clk low), 1 = H half
  logic [4:0]                     bit_cnt;
  logic [31:0]                    tx_sr;        // {command, address}, MSB leaves first
  logic [7:0]                     rx_sr;
  logic [ByteCountBitWidth-1:0]   bytes_left;
  logic                           shift_last;
  logic                           byte_end;

  // End-of-phase decodes shared by next-state and datapath logic
  always_comb begin
    shift_last = phase && (bit_cnt == 5'd31);
    byte_end   = phase && (bit_cnt == 5'd7);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ResetState;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      StStartup: if (startup_cnt == StartupWaitCycles - 1) state_next = StIdle;
      StIdle:    if (start && (byte_count != '0)) state_next = StShift;
      StShift:   if (shift_last) state_next = StRead;
      StRead:    if (byte_end && (bytes_left == OneByte)) state_next = StIdle;
      default:   state_next = ResetState;
    endcase
  end

  // Datapath: startup counter, bit timing, shift registers and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startup_cnt    <= '0;
      phase          <= 1'b0;
      bit_cnt        <= '0;
      tx_sr          <= '0;
      rx_sr          <= '0;
      bytes_left     <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      done           <= 1'b0;
      unique case (state)
        StStartup: begin
          startup_cnt <= startup_cnt + 32'd1;
        end
        StIdle: begin
          if (start) begin
            if (byte_count == '0) begin
              done <= 1'b1;
            end else begin
              tx_sr      <= {ReadCommand, address};
              bytes_left <= byte_count;
              phase      <= 1'b0;
              bit_cnt    <= '0;
            end
          end
        end
        StShift: begin
          phase <= ~phase;
          if (phase) begin
            tx_sr   <= {tx_sr[30:0], 1'b0};
            bit_cnt <= shift_last ? 5'd0 : bit_cnt + 5'd1;
          end
        end
        StRead: begin
          phase <= ~phase;
          // miso is captured on the edge that raises flash_clk (end of L)
          if (!phase) begin
            rx_sr <= {rx_sr[6:0], flash_miso};
          end else if (byte_end) begin
            bit_cnt        <= '0;
            data_out       <= rx_sr;
            data_out_valid <= 1'b1;
            bytes_left     <= bytes_left - OneByte;
            if (bytes_left == OneByte) done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: chip select and SPI clock follow the state directly so a
  // reset releases the bus in the same instant
  always_comb begin
    busy       = (state != StIdle);
    flash_cs_n = !((state == StShift) || (state == StRead));
    flash_clk  = ((state == StShift) || (state == StRead)) && phase;
    flash_mosi = (state == StShift) && tx_sr[31];
  end

endmodule
